// File: rtl/gray_arb_pkg.sv
// Shared opcodes, FSM state type and helpers for the gray counter arbiter.
package gray_arb_pkg;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_DEC    = 3'd0;
  localparam logic [OPW-1:0] OP_INC    = 3'd1;
  localparam logic [OPW-1:0] OP_RDBIN  = 3'd2;
  localparam logic [OPW-1:0] OP_RDGRAY = 3'd3;
  localparam logic [OPW-1:0] OP_WRBIN  = 3'd4;
  localparam logic [OPW-1:0] OP_WRGRAY = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op <= OP_WRGRAY;
  endfunction
endpackage

// File: rtl/gray_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping to 0.
module gray_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);
  logic [IW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = IW'((int'(ptr) + k) % NREQ);
      if (!gnt_any && req[sel]) begin
        gnt_any  = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end
endmodule

// File: rtl/gray_counter_arbiter.sv
// Shares one GrayCounter between NREQ requesters, one command in flight.
// Optional GRAY_ARB_STATS_EN adds saturating command/illegal-opcode counters.
module gray_counter_arbiter
  import gray_arb_pkg::*;
#(
  parameter int width = 4,
  parameter int NREQ  = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_enq__ENA,
  input  logic [OPW*NREQ-1:0]   req_enq_op,
  input  logic [width*NREQ-1:0] req_enq_v,
  output logic [NREQ-1:0]       req_enq__RDY,
  output logic                  method_decrement__ENA,
  input  logic                  method_decrement__RDY,
  output logic                  method_increment__ENA,
  input  logic                  method_increment__RDY,
  output logic                  method_writeBin__ENA,
  output logic [width-1:0]      method_writeBin_v,
  input  logic                  method_writeBin__RDY,
  output logic                  method_writeGray__ENA,
  output logic [width-1:0]      method_writeGray_v,
  input  logic                  method_writeGray__RDY,
  input  logic [width-1:0]      method_readBin,
  input  logic                  method_readBin__RDY,
  input  logic [width-1:0]      method_readGray,
  input  logic                  method_readGray__RDY,
  output logic [NREQ-1:0]       rsp_enq__ENA,
  output logic [width-1:0]      rsp_enq_v,
  input  logic [NREQ-1:0]       rsp_enq__RDY
`ifdef GRAY_ARB_STATS_EN
  ,
  output logic [15:0]           stat_cmds,
  output logic [15:0]           stat_illegal
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [IW-1:0]   ptr, id_q, gnt_idx;
  logic [NREQ-1:0] gnt, id_oh;
  logic            gnt_any, accept, exec, exec_done, rd_cap, rsp_hs;
  logic [OPW-1:0]  op_q, op_sel;
  logic [width-1:0] v_q, v_sel, rsp_q, rd_val;

  gray_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req_enq__ENA),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign op_sel = req_enq_op[gnt_idx*OPW +: OPW];
  assign v_sel  = req_enq_v[gnt_idx*width +: width];
  // Gating with nRST keeps the accept strobe quiet while reset is held.
  assign accept = nRST && (state == IDLE) && gnt_any;
  assign req_enq__RDY = accept ? gnt : '0;

  assign exec = (state == EXEC);
  assign method_decrement__ENA = exec && (op_q == OP_DEC)    && method_decrement__RDY;
  assign method_increment__ENA = exec && (op_q == OP_INC)    && method_increment__RDY;
  assign method_writeBin__ENA  = exec && (op_q == OP_WRBIN)  && method_writeBin__RDY;
  assign method_writeGray__ENA = exec && (op_q == OP_WRGRAY) && method_writeGray__RDY;
  assign method_writeBin_v  = v_q;
  assign method_writeGray_v = v_q;

  assign id_oh        = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
  assign rsp_enq__ENA = (state == RESP) ? id_oh : '0;
  assign rsp_enq_v    = rsp_q;
  assign rsp_hs       = (rsp_enq__RDY & id_oh) != '0;

  always_comb begin
    exec_done = 1'b0;
    rd_cap    = 1'b0;
    rd_val    = method_readBin;
    case (op_q)
      OP_DEC:    exec_done = method_decrement__RDY;
      OP_INC:    exec_done = method_increment__RDY;
      OP_WRBIN:  exec_done = method_writeBin__RDY;
      OP_WRGRAY: exec_done = method_writeGray__RDY;
      OP_RDBIN:  rd_cap    = method_readBin__RDY;
      OP_RDGRAY: begin
        rd_cap = method_readGray__RDY;
        rd_val = method_readGray;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ptr   <= '0;
      op_q  <= '0;
      v_q   <= '0;
      id_q  <= '0;
      rsp_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op_sel;
          v_q  <= v_sel;
          id_q <= gnt_idx;
          ptr  <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          // Illegal opcodes are consumed here and never reach the counter.
          if (op_legal(op_sel)) state <= EXEC;
        end
        EXEC: if (rd_cap) begin
          rsp_q <= rd_val;
          state <= RESP;
        end else if (exec_done) begin
          state <= IDLE;
        end
        RESP: if (rsp_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRAY_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_cmds    <= '0;
      stat_illegal <= '0;
    end else if (accept) begin
      if (op_legal(op_sel)) begin
        if (stat_cmds != 16'hFFFF) stat_cmds <= stat_cmds + 1'b1;
      end else if (stat_illegal != 16'hFFFF) begin
        stat_illegal <= stat_illegal + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Scoreboard bench: driver predicts grant/method/response events, monitor checks them.
module tb_gray_counter_arbiter;
  localparam int W   = 4;
  localparam int N   = 4;
  localparam int OPB = 3 * N;
  localparam int VB  = W * N;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [N-1:0]   req_ena = '0;
  logic [OPB-1:0] req_op = '0;
  logic [VB-1:0]  req_v = '0;
  logic [N-1:0]   req_rdy;
  logic dec_ena, inc_ena, wb_ena, wg_ena;
  logic dec_rdy = 1'b0, inc_rdy = 1'b0, wb_rdy = 1'b0, wg_rdy = 1'b0;
  logic [W-1:0] wb_v, wg_v;
  logic [W-1:0] rb = '0, rg = '0;
  logic rb_rdy = 1'b0, rg_rdy = 1'b0;
  logic [N-1:0] rsp_ena;
  logic [N-1:0] rsp_rdy = '0;
  logic [W-1:0] rsp_v;
`ifdef GRAY_ARB_STATS_EN
  logic [15:0] st_cmds, st_ill;
`endif

  gray_counter_arbiter #(.width(W), .NREQ(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_enq__ENA(req_ena), .req_enq_op(req_op), .req_enq_v(req_v), .req_enq__RDY(req_rdy),
    .method_decrement__ENA(dec_ena), .method_decrement__RDY(dec_rdy),
    .method_increment__ENA(inc_ena), .method_increment__RDY(inc_rdy),
    .method_writeBin__ENA(wb_ena), .method_writeBin_v(wb_v), .method_writeBin__RDY(wb_rdy),
    .method_writeGray__ENA(wg_ena), .method_writeGray_v(wg_v), .method_writeGray__RDY(wg_rdy),
    .method_readBin(rb), .method_readBin__RDY(rb_rdy),
    .method_readGray(rg), .method_readGray__RDY(rg_rdy),
    .rsp_enq__ENA(rsp_ena), .rsp_enq_v(rsp_v), .rsp_enq__RDY(rsp_rdy)
`ifdef GRAY_ARB_STATS_EN
    , .stat_cmds(st_cmds), .stat_illegal(st_ill)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         kind;   // 0 accept, 1 method fire, 2 response
    int         id;
    int         op;
    logic [W-1:0] v;
  } ev_t;

  ev_t exq[$];
  int checks = 0, passes = 0, fails = 0;
  int mptr = 0, m_cmds = 0, m_ill = 0;
  int inc_cnt = 0, rsp_vis = 0;

  function automatic void chk(input string nm, input bit ok, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_ev(input int k, input int id, input int op, input logic [W-1:0] v);
    ev_t e;
    e.kind = k; e.id = id; e.op = op; e.v = v;
    exq.push_back(e);
  endfunction

  // Method port position: dec=0, inc=1, writeBin=2, writeGray=3.
  function automatic int mbit(input int op);
    return (op == 0) ? 0 : (op == 1) ? 1 : (op == 4) ? 2 : 3;
  endfunction

  always @(negedge CLK) begin
    ev_t e;
    logic [3:0] m, mr, em;
    logic [W-1:0] vo;
    if (nRST) begin
      m  = {wg_ena, wb_ena, inc_ena, dec_ena};
      mr = {wg_rdy, wb_rdy, inc_rdy, dec_rdy};
      if (inc_ena) inc_cnt++;
      if (rsp_ena != '0) rsp_vis++;
      if (req_rdy != '0) begin
        if (exq.size() == 0) chk("unexpected_accept", 1'b0, req_rdy, 0);
        else begin
          e = exq.pop_front();
          chk("accept", e.kind == 0 && req_rdy == (N'(1) << e.id), req_rdy, 1 << e.id);
        end
      end
      if (m != '0) begin
        chk("method_ena_onehot_rdy", $countones(m) == 1 && (m & mr) == m, m, mr);
        if (exq.size() == 0) chk("unexpected_method", 1'b0, m, 0);
        else begin
          e  = exq.pop_front();
          em = 4'b0001 << mbit(e.op);
          vo = m[3] ? wg_v : wb_v;
          chk("method", e.kind == 1 && m == em && (e.op < 4 || vo == e.v),
              {m, vo}, {em, e.v});
        end
      end
      if ((rsp_ena & rsp_rdy) != '0) begin
        if (exq.size() == 0) chk("unexpected_rsp", 1'b0, rsp_ena, 0);
        else begin
          e = exq.pop_front();
          chk("rsp", e.kind == 2 && rsp_ena == (N'(1) << e.id) && rsp_v == e.v,
              {rsp_ena, rsp_v}, {N'(1) << e.id, e.v});
        end
      end
    end
  end

  task automatic drive_rdys(input int pm, input int pr);
    dec_rdy = ($urandom_range(99) < pm);
    inc_rdy = ($urandom_range(99) < pm);
    wb_rdy  = ($urandom_range(99) < pm);
    wg_rdy  = ($urandom_range(99) < pm);
    rb_rdy  = ($urandom_range(99) < pm);
    rg_rdy  = ($urandom_range(99) < pm);
    for (int i = 0; i < N; i++) rsp_rdy[i] = ($urandom_range(99) < pr);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    req_ena = '0;
    nRST = 1'b0;
    #1;
    chk("reset_outputs", {req_rdy, dec_ena, inc_ena, wb_ena, wg_ena, rsp_ena, rsp_v} == '0,
        {req_rdy, dec_ena, inc_ena, wb_ena, wg_ena, rsp_ena, rsp_v}, 0);
    exq.delete();
    mptr = 0; m_cmds = 0; m_ill = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // Issue one command set; expected events come from round-robin rules on the request vector.
  task automatic run_txn(input logic [N-1:0] ena, input logic [OPB-1:0] ops, input logic [VB-1:0] vs,
                         input int mhold, input int rhold, input int p,
                         input logic [W-1:0] rbv, input logic [W-1:0] rgv, output int lat);
    int g, op, c;
    @(posedge CLK); #1;
    rb = rbv; rg = rgv;
    req_ena = ena; req_op = ops; req_v = vs;
    drive_rdys(mhold > 0 ? 0 : p, rhold > 0 ? 0 : p);
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && ena[(mptr + k) % N]) g = (mptr + k) % N;
    lat = 0;
    if (g < 0) return;
    push_ev(0, g, 0, '0);
    mptr = (g + 1) % N;
    op = int'(ops[3*g +: 3]);
    if (op <= 1 || op == 4 || op == 5) begin push_ev(1, g, op, vs[W*g +: W]); m_cmds++; end
    else if (op == 2) begin push_ev(2, g, op, rbv); m_cmds++; end
    else if (op == 3) begin push_ev(2, g, op, rgv); m_cmds++; end
    else m_ill++;
    c = 0;
    while (exq.size() != 0 && c < 200) begin
      @(posedge CLK); #1;
      c++;
      req_ena = '0;
      req_op = OPB'($urandom);
      req_v  = VB'($urandom);
      drive_rdys(c < mhold ? 0 : p, c < rhold ? 0 : p);
    end
    if (exq.size() != 0) begin
      chk("txn_timeout", 1'b0, exq.size(), 0);
      exq.delete();
    end
    lat = c;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, s, c;
    logic [N-1:0] e;
    do_reset();

    // writeBin of 9 from req0: fire one cycle after accept, idle the next.
    run_txn(4'b0001, OPB'(4), VB'(9), 0, 0, 100, '0, '0, lat);
    chk("wr_latency", lat == 2, lat, 2);

    // All four requesters hold increment: round-robin 0,1,2,3,0, one fire per two cycles.
    do_reset();
    @(posedge CLK); #1;
    drive_rdys(100, 100);
    req_ena = '1;
    req_op = {N{3'd1}};
    for (int i = 0; i < 5; i++) begin
      push_ev(0, i % N, 0, '0);
      push_ev(1, i % N, 1, '0);
    end
    mptr = 1; m_cmds += 5;
    s = inc_cnt;
    repeat (10) @(posedge CLK);
    #1 req_ena = '0;
    chk("burst_inc_count", inc_cnt - s == 5, inc_cnt - s, 5);
    chk("burst_drained", exq.size() == 0, exq.size(), 0);
    exq.delete();

    // Illegal opcode from req1: accepted and dropped, pointer moves to 2.
    run_txn(4'b0010, OPB'(7 << 3), '0, 0, 0, 100, '0, '0, lat);
    chk("illegal_latency", lat == 1, lat, 1);

    // req0 and req2 both ask; pointer at 2 picks req2's writeGray, held off 4 EXEC cycles.
    run_txn(4'b0101, OPB'(5 << 6), VB'(6 << 8), 5, 0, 100, '0, '0, lat);
    chk("wrgray_latency", lat == 6, lat, 6);

    // readBin from req2 with response ready held low 3 RESP cycles.
    s = rsp_vis;
    run_txn(4'b0100, OPB'(2 << 6), '0, 0, 5, 100, 4'hA, 4'h5, lat);
    chk("rd_latency", lat == 6, lat, 6);
    chk("rsp_held_cycles", rsp_vis - s == 4, rsp_vis - s, 4);

    // Reset while a response is pending from req2, then grant restarts at pointer 0.
    @(posedge CLK); #1;
    drive_rdys(100, 0);
    rb = 4'h3;
    req_ena = 4'b0100; req_op = OPB'(2 << 6);
    push_ev(0, 2, 0, '0);
    mptr = 3;
    c = 0;
    do begin
      @(posedge CLK); #1;
      req_ena = '0;
      c++;
    end while (rsp_ena == '0 && c < 20);
    chk("reach_resp", rsp_ena == 4'b0100, rsp_ena, 4'b0100);
    do_reset();
    run_txn(4'b1010, OPB'((4 << 9) | (1 << 3)), '0, 0, 0, 100, '0, '0, lat);
    chk("post_reset_latency", lat == 2, lat, 2);

    // Randomized traffic against the round-robin model.
    for (int t = 0; t < 40; t++) begin
      e = N'($urandom_range(1, (1 << N) - 1));
      run_txn(e, OPB'($urandom), VB'($urandom), 0, 0, $urandom_range(40, 100),
              W'($urandom), W'($urandom), lat);
    end

`ifdef GRAY_ARB_STATS_EN
    chk("stat_cmds", st_cmds == 16'(m_cmds), st_cmds, m_cmds);
    chk("stat_illegal", st_ill == 16'(m_ill), st_ill, m_ill);
`endif

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
